// File: rtl/load_store_unit_if.sv
// ---------------------------------------------------------------------------
// load_store_unit_if
//
// Bundles the pipeline request/response handshake and the data-memory bus of
// the load/store unit.
//
// Signals:
//   req_valid, req_ready, req_write, req_byte, req_signed, req_addr,
//   req_wdata   - request from the EX/MEM stage (req_ready driven by the LSU)
//   resp_valid, resp_rdata, resp_fault, busy
//               - one-cycle response and pipeline stall request
//   mem_wr_enable, mem_rd_enable, mem_addr_bus, mem_in_bus,
//   mem_number_of_byte - LSU-driven memory controls
//   mem_out_bus - registered read data returned by the memory
//
// Modports:
//   slave  - the load/store unit itself
//   master - the environment (pipeline + memory) around it
// ---------------------------------------------------------------------------
interface load_store_unit_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic                  req_byte;
    logic                  req_signed;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;

    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_fault;
    logic                  busy;

    logic                  mem_wr_enable;
    logic                  mem_rd_enable;
    logic [ADDR_WIDTH-1:0] mem_addr_bus;
    logic [DATA_WIDTH-1:0] mem_in_bus;
    logic                  mem_number_of_byte;
    logic [DATA_WIDTH-1:0] mem_out_bus;

    modport slave (
        input  req_valid, req_write, req_byte, req_signed, req_addr, req_wdata,
        input  mem_out_bus,
        output req_ready, resp_valid, resp_rdata, resp_fault, busy,
        output mem_wr_enable, mem_rd_enable, mem_addr_bus, mem_in_bus,
        output mem_number_of_byte
    );

    modport master (
        output req_valid, req_write, req_byte, req_signed, req_addr, req_wdata,
        output mem_out_bus,
        input  req_ready, resp_valid, resp_rdata, resp_fault, busy,
        input  mem_wr_enable, mem_rd_enable, mem_addr_bus, mem_in_bus,
        input  mem_number_of_byte
    );
endinterface

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//
// Memory-stage controller in front of a byte-addressed 16-bit data memory.
// Takes one load/store at a time, drives the memory's enables/address/data,
// returns load data with sign/zero extension, and performs byte stores as a
// read-modify-write because the memory always writes two bytes. Out-of-range
// accesses are answered with a fault and never reach the memory.
//
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high reset
//   bus   - load_store_unit_if.slave: request/response handshake and the
//           memory bus (see the interface file for the signal list)
//
// State walk (all outputs registered, set on the edge entering a state):
//   load       : IDLE -> RD_ISSUE -> RD_WAIT -> RESP
//   word store : IDLE -> WR_ISSUE -> RESP
//   byte store : IDLE -> RD_ISSUE -> RD_WAIT -> WR_ISSUE -> RESP
//   fault      : IDLE -> RESP
// ---------------------------------------------------------------------------
module load_store_unit #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int MEM_LIMIT  = 1024
) (
    input  logic              clk,
    input  logic              reset,
    load_store_unit_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        WR_ISSUE,
        RESP
    } state_t;

    state_t     state;

    // Request holding registers. The address needs no copy of its own: the
    // memory address bus is loaded at accept and holds it for the access.
    logic       op_write;
    logic       op_byte;
    logic       op_signed;
    logic [7:0] op_wdata_lo;

    logic       accept;
    logic       fault;
    logic       byte_load;

    assign bus.req_ready = (state == IDLE) && !reset;
    assign bus.busy      = (state != IDLE);
    assign accept        = bus.req_valid && bus.req_ready;
    assign byte_load     = bus.req_byte && !bus.req_write;

    // Range check on the incoming request. Anything touching addr+1 (word
    // accesses and the read-modify-write of a byte store) must also keep
    // addr+1 inside the implemented range; only a byte load may use the
    // last byte.
    // NOTE: fault gets a default before any branch, so every path assigns it
    // and no latch is inferred.
    always_comb begin
        fault = 1'b0;
        if (32'(bus.req_addr) >= 32'(MEM_LIMIT)) begin
            fault = 1'b1;
        end else if (32'(bus.req_addr) == 32'(MEM_LIMIT - 1) && !byte_load) begin
            fault = 1'b1;
        end
    end

    // NOTE: all state and registered outputs use non-blocking assignments so
    // every register sees the values from before the edge, independent of
    // statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state                  <= IDLE;
            op_write               <= 1'b0;
            op_byte                <= 1'b0;
            op_signed              <= 1'b0;
            op_wdata_lo            <= '0;
            bus.resp_valid         <= 1'b0;
            bus.resp_fault         <= 1'b0;
            bus.resp_rdata         <= '0;
            bus.mem_wr_enable      <= 1'b0;
            bus.mem_rd_enable      <= 1'b0;
            bus.mem_addr_bus       <= '0;
            bus.mem_in_bus         <= '0;
            bus.mem_number_of_byte <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_write       <= bus.req_write;
                        op_byte        <= bus.req_byte;
                        op_signed      <= bus.req_signed;
                        op_wdata_lo    <= bus.req_wdata[7:0];
                        bus.resp_rdata <= '0;
                        if (fault) begin
                            // Memory bus is left untouched on a fault.
                            state          <= RESP;
                            bus.resp_valid <= 1'b1;
                            bus.resp_fault <= 1'b1;
                        end else if (bus.req_write && !bus.req_byte) begin
                            state                  <= WR_ISSUE;
                            bus.mem_wr_enable      <= 1'b1;
                            bus.mem_addr_bus       <= bus.req_addr;
                            bus.mem_in_bus         <= bus.req_wdata;
                            bus.mem_number_of_byte <= 1'b1;
                        end else begin
                            // Loads and the read half of a byte store. A byte
                            // store reads the whole word to recover addr+1.
                            state                  <= RD_ISSUE;
                            bus.mem_rd_enable      <= 1'b1;
                            bus.mem_addr_bus       <= bus.req_addr;
                            bus.mem_number_of_byte <= !byte_load;
                        end
                    end
                end

                RD_ISSUE: begin
                    bus.mem_rd_enable <= 1'b0;
                    state             <= RD_WAIT;
                end

                RD_WAIT: begin
                    // mem_out_bus carries the word read on the previous edge.
                    if (op_write) begin
                        // Merge: keep the high byte just read, replace the low.
                        state                  <= WR_ISSUE;
                        bus.mem_wr_enable      <= 1'b1;
                        bus.mem_number_of_byte <= 1'b1;
                        bus.mem_in_bus         <= {bus.mem_out_bus[15:8], op_wdata_lo};
                    end else begin
                        state          <= RESP;
                        bus.resp_valid <= 1'b1;
                        bus.resp_fault <= 1'b0;
                        if (!op_byte) begin
                            bus.resp_rdata <= bus.mem_out_bus;
                        end else if (op_signed) begin
                            bus.resp_rdata <= {{(DATA_WIDTH-8){bus.mem_out_bus[7]}},
                                               bus.mem_out_bus[7:0]};
                        end else begin
                            bus.resp_rdata <= {{(DATA_WIDTH-8){1'b0}},
                                               bus.mem_out_bus[7:0]};
                        end
                    end
                end

                WR_ISSUE: begin
                    bus.mem_wr_enable <= 1'b0;
                    state             <= RESP;
                    bus.resp_valid    <= 1'b1;
                    bus.resp_fault    <= 1'b0;
                    bus.resp_rdata    <= '0;
                end

                RESP: begin
                    bus.resp_valid <= 1'b0;
                    bus.resp_fault <= 1'b0;
                    bus.resp_rdata <= '0;
                    state          <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
//
// Directed bench for load_store_unit. Surrounds the unit with a behavioural
// 1024-byte little-endian memory (registered read data), issues hand-picked
// loads/stores/faults, and compares latency, response data, fault flag and
// memory-pulse counts against hand-computed values.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

    localparam int ADDR_WIDTH = 16;
    localparam int DATA_WIDTH = 16;
    localparam int MEM_LIMIT  = 1024;

    logic clk = 1'b0;
    logic reset;

    load_store_unit_if #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) bus ();

    load_store_unit #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .MEM_LIMIT (MEM_LIMIT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural data memory ----------------
    logic [7:0]  mem [0:MEM_LIMIT-1];
    logic [15:0] out_q;
    logic [9:0]  ma, ma1;

    assign ma              = bus.mem_addr_bus[9:0];
    assign ma1             = ma + 10'd1;
    assign bus.mem_out_bus = out_q;

    always @(posedge clk) begin
        if (bus.mem_wr_enable) begin
            mem[ma] <= bus.mem_in_bus[7:0];
            if (bus.mem_number_of_byte) mem[ma1] <= bus.mem_in_bus[15:8];
        end
        if (reset) out_q <= '0;
        else if (bus.mem_rd_enable)
            out_q <= bus.mem_number_of_byte ? {mem[ma1], mem[ma]} : {8'h00, mem[ma]};
    end

    // ---------------- bus monitor (samples the settled previous cycle) ----
    int          rd_cnt = 0, wr_cnt = 0, both_cnt = 0, resp_cnt = 0;
    logic [15:0] last_in = '0;
    logic        last_wr_nob = 1'b0, last_rd_nob = 1'b0;

    always @(posedge clk) begin
        if (bus.mem_rd_enable && bus.mem_wr_enable) both_cnt++;
        if (bus.mem_rd_enable) begin
            rd_cnt++;
            last_rd_nob = bus.mem_number_of_byte;
        end
        if (bus.mem_wr_enable) begin
            wr_cnt++;
            last_in     = bus.mem_in_bus;
            last_wr_nob = bus.mem_number_of_byte;
        end
        if (bus.resp_valid) resp_cnt++;
    end

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one request from IDLE and wait (bounded) for its response.
    // lat = cycles from the accept edge to the resp_valid cycle.
    task automatic run_req(input logic w, input logic b, input logic s,
                           input logic [15:0] a, input logic [15:0] d,
                           output int lat, output logic [15:0] rdata,
                           output logic fault, output int drd, output int dwr);
        int rd0, wr0;
        @(negedge clk);
        rd0            = rd_cnt;
        wr0            = wr_cnt;
        bus.req_valid  = 1'b1;
        bus.req_write  = w;
        bus.req_byte   = b;
        bus.req_signed = s;
        bus.req_addr   = a;
        bus.req_wdata  = d;
        @(negedge clk);
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.resp_valid && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        rdata = bus.resp_rdata;
        fault = bus.resp_fault;
        drd   = rd_cnt - rd0;
        dwr   = wr_cnt - wr0;
    endtask

    task automatic txn(input string tag, input logic w, input logic b, input logic s,
                       input logic [15:0] a, input logic [15:0] d,
                       input int e_lat, input logic [15:0] e_rdata, input logic e_fault,
                       input int e_rd, input int e_wr);
        int          lat, drd, dwr;
        logic [15:0] rdata;
        logic        fault;
        run_req(w, b, s, a, d, lat, rdata, fault, drd, dwr);
        check($sformatf("%s.latency", tag), lat, e_lat);
        check($sformatf("%s.rdata", tag), rdata, e_rdata);
        check($sformatf("%s.fault", tag), fault, e_fault);
        check($sformatf("%s.rd_pulses", tag), drd, e_rd);
        check($sformatf("%s.wr_pulses", tag), dwr, e_wr);
    endtask

    initial begin
        int          lat;
        int          resp0;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_byte   = 1'b0;
        bus.req_signed = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Reset / idle state
        check("idle.req_ready", bus.req_ready, 1);
        check("idle.busy", bus.busy, 0);
        check("idle.mem_enables", {bus.mem_wr_enable, bus.mem_rd_enable}, 0);
        check("idle.mem_addr_in", {bus.mem_addr_bus, bus.mem_in_bus}, 0);
        check("idle.mem_nob", bus.mem_number_of_byte, 0);
        check("idle.resp", {bus.resp_valid, bus.resp_fault, bus.resp_rdata}, 0);

        // Word store then word load
        txn("st_w_10", 1, 0, 0, 16'h0010, 16'hBEEF, 2, 16'h0000, 0, 0, 1);
        check("st_w_10.in_bus", last_in, 16'hBEEF);
        check("st_w_10.nob", last_wr_nob, 1);
        txn("ld_w_10", 0, 0, 0, 16'h0010, 16'h0000, 3, 16'hBEEF, 0, 1, 0);
        check("ld_w_10.nob", last_rd_nob, 1);

        // [0x20]=0x85, [0x21]=0x12, then extensions
        txn("st_w_20", 1, 0, 0, 16'h0020, 16'h1285, 2, 16'h0000, 0, 0, 1);
        txn("ld_bs_20", 0, 1, 1, 16'h0020, 16'h0000, 3, 16'hFF85, 0, 1, 0);
        check("ld_bs_20.nob", last_rd_nob, 0);
        txn("ld_bu_20", 0, 1, 0, 16'h0020, 16'h0000, 3, 16'h0085, 0, 1, 0);
        txn("ld_w_20", 0, 0, 0, 16'h0020, 16'h0000, 3, 16'h1285, 0, 1, 0);
        txn("ld_bs_21", 0, 1, 1, 16'h0021, 16'h0000, 3, 16'h0012, 0, 1, 0);

        // Byte store RMW: upper wdata byte must be ignored
        txn("st_b_20", 1, 1, 0, 16'h0020, 16'hAA77, 4, 16'h0000, 0, 1, 1);
        check("st_b_20.in_bus", last_in, 16'h1277);
        check("st_b_20.rd_nob", last_rd_nob, 1);
        check("st_b_20.wr_nob", last_wr_nob, 1);
        txn("ld_w_20b", 0, 0, 0, 16'h0020, 16'h0000, 3, 16'h1277, 0, 1, 0);

        // Top of memory: [0x3FE]=0x5A, [0x3FF]=0xC3
        txn("st_w_3fe", 1, 0, 0, 16'h03FE, 16'hC35A, 2, 16'h0000, 0, 0, 1);
        txn("ld_bs_3ff", 0, 1, 1, 16'h03FF, 16'h0000, 3, 16'hFFC3, 0, 1, 0);

        // Faults: one cycle, no memory pulses, rdata 0
        txn("flt_ld_w_3ff", 0, 0, 0, 16'h03FF, 16'h0000, 1, 16'h0000, 1, 0, 0);
        txn("flt_st_b_3ff", 1, 1, 0, 16'h03FF, 16'h0011, 1, 16'h0000, 1, 0, 0);
        txn("flt_ld_w_400", 0, 0, 0, 16'h0400, 16'h0000, 1, 16'h0000, 1, 0, 0);
        txn("flt_st_w_3ff", 1, 0, 0, 16'h03FF, 16'h1234, 1, 16'h0000, 1, 0, 0);
        txn("flt_ld_b_ffff", 0, 1, 1, 16'hFFFF, 16'h0000, 1, 16'h0000, 1, 0, 0);
        // Top bytes must be unharmed by the faulting stores
        txn("ld_w_3fe", 0, 0, 0, 16'h03FE, 16'h0000, 3, 16'hC35A, 0, 1, 0);

        // Reset asserted while a load sits in RD_WAIT
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_byte  = 1'b0;
        bus.req_addr  = 16'h0010;
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("rst_mid.rd_issue", bus.mem_rd_enable, 1);
        @(negedge clk);
        check("rst_mid.in_rd_wait", {bus.busy, bus.mem_rd_enable}, 2'b10);
        resp0 = resp_cnt;
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid.busy", bus.busy, 0);
        check("rst_mid.enables", {bus.mem_wr_enable, bus.mem_rd_enable}, 0);
        check("rst_mid.resp_valid", bus.resp_valid, 0);
        check("rst_mid.ready_in_reset", bus.req_ready, 0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid.ready_after", bus.req_ready, 1);
        repeat (3) @(negedge clk);
        check("rst_mid.no_resp", resp_cnt - resp0, 0);

        // Back-to-back with req_valid held high
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_byte  = 1'b0;
        bus.req_addr  = 16'h0030;
        bus.req_wdata = 16'h1234;
        @(negedge clk);                           // WR_ISSUE
        bus.req_write = 1'b0;                     // queued load, must wait
        bus.req_wdata = 16'h0000;
        check("b2b.c1", {bus.req_ready, bus.busy, bus.mem_wr_enable}, 3'b011);
        @(negedge clk);                           // RESP
        check("b2b.c2", {bus.req_ready, bus.busy, bus.resp_valid}, 3'b011);
        @(negedge clk);                           // IDLE, accept on next edge
        check("b2b.c3", {bus.req_ready, bus.busy}, 2'b10);
        @(negedge clk);                           // RD_ISSUE of the load
        bus.req_valid = 1'b0;
        check("b2b.c4", {bus.req_ready, bus.busy, bus.mem_rd_enable}, 3'b011);
        check("b2b.st_in_bus", last_in, 16'h1234);
        lat = 1;
        while (!bus.resp_valid && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        check("b2b.ld_latency", lat, 3);
        check("b2b.ld_rdata", bus.resp_rdata, 16'h1234);
        @(negedge clk);
        check("b2b.idle_after", {bus.req_ready, bus.busy}, 2'b10);

        check("enable_exclusive", both_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
